// File: rtl/sommatore_seriale_ctrl_if.sv
// Requester-side bus of the serial adder sequencer: request/operands in,
// status and registered result out.
interface sommatore_seriale_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ripin;
  logic         busy;
  logic         done;
  logic [W-1:0] somma;
  logic         ripout;

  // Requester drives the operation, observes status and result
  modport master (
    output start, a, b, ripin,
    input  busy, done, somma, ripout
  );

  // Sequencer accepts the operation, drives status and result
  modport slave (
    input  start, a, b, ripin,
    output busy, done, somma, ripout
  );
endinterface

// File: rtl/sommatore_seriale_ctrl.sv
// Serial W-bit adder: one 2-bit full-adder slice reused W/2 times, LSB pair
// first, with the inter-step carry held in a register.

// 2-bit full-adder slice
module fulladder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  // Plain 2-bit add with carry-in
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
  end
endmodule

module sommatore_seriale_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sommatore_seriale_ctrl_if.slave bus
);
  localparam int unsigned STEPS = W / 2;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q,  state_d;
  logic [W-1:0]  opa_q,    opa_d;
  logic [W-1:0]  opb_q,    opb_d;
  logic          carry_q,  carry_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  part_q,   part_d;
  logic [W-1:0]  somma_q,  somma_d;
  logic          ripout_q, ripout_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;

  logic [1:0]    slice_s;
  logic          slice_c;
  logic [W-1:0]  part_next;

  fulladder_2bit u_slice (
    .a    (opa_q[1:0]),
    .b    (opb_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // Slice sum enters the partial sum from the MSB end; shift form keeps W=2 legal
  always_comb begin
    part_next = (part_q >> 2) | (W'(slice_s) << (W - 2));
  end

  // Next-state and next-output logic; status flags follow the next state
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    part_d   = part_q;
    somma_d  = somma_q;
    ripout_d = ripout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.ripin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 2;
        opb_d   = opb_q >> 2;
        carry_d = slice_c;
        part_d  = part_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          somma_d  = part_next;
          ripout_d = slice_c;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // All state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      part_q   <= '0;
      somma_q  <= '0;
      ripout_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      somma_q  <= somma_d;
      ripout_q <= ripout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.somma  = somma_q;
  assign bus.ripout = ripout_q;
endmodule
